// File: rtl/key_event.sv
// Press-pattern classifier: turns the debounced key level into one-cycle
// short / long / repeat / double-click event pulses.
module key_event #(
  parameter int CNT_W       = 26,
  parameter int LONG_CNT    = 50_000_000,
  parameter int DBL_GAP_CNT = 12_500_000,
  parameter int REPEAT_CNT  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic repeat_press,
  output logic double_click,
  output logic busy
);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HOLD} state_t;

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DBL_M1  = CNT_W'(DBL_GAP_CNT - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CNT - 1);
  localparam bit               REP_EN  = (REPEAT_CNT != 0);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             key_d, rise;
  logic             short_nx, long_nx, repeat_nx, double_nx;

  assign rise = key_state & ~key_d;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    short_nx  = 1'b0;
    long_nx   = 1'b0;
    repeat_nx = 1'b0;
    double_nx = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (rise) state_nx = PRESS1;
      end
      PRESS1: begin
        // release wins over the long-press threshold on the same cycle
        if (!key_state) begin
          state_nx = WAIT2;
          cnt_nx   = '0;
        end else if (cnt == LONG_M1) begin
          long_nx  = 1'b1;
          state_nx = HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT2: begin
        if (key_state) begin
          state_nx = PRESS2;
          cnt_nx   = '0;
        end else if (cnt == DBL_M1) begin
          short_nx = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESS2: begin
        if (!key_state) begin
          double_nx = 1'b1;
          state_nx  = IDLE;
          cnt_nx    = '0;
        end
      end
      HOLD: begin
        if (!key_state) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (REP_EN && cnt == REP_M1) begin
          repeat_nx = 1'b1;
          cnt_nx    = '0;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // key_d resets high so a key held through reset must be re-pressed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      key_d        <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
      double_click <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      key_d        <= key_state;
      short_press  <= short_nx;
      long_press   <= long_nx;
      repeat_press <= repeat_nx;
      double_click <= double_nx;
      busy         <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: directed timing scenarios plus random press/release
// traffic compared each cycle against an elapsed-time reference model.
module tb_key_event;
  localparam int L = 20, D = 8, R = 5;

  logic clk = 1'b0;
  logic rst, key_state;
  logic short_press, long_press, repeat_press, double_click, busy;

  key_event #(.CNT_W(8), .LONG_CNT(L), .DBL_GAP_CNT(D), .REPEAT_CNT(R)) dut (
    .clk(clk), .rst(rst), .key_state(key_state),
    .short_press(short_press), .long_press(long_press),
    .repeat_press(repeat_press), .double_click(double_click), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, fails = 0;
  // reference model: a sequence is described by when it started and when
  // the first release happened; pulses fall out of elapsed-time arithmetic
  int t = 0, p1_t = -1, rel_t = -1;
  bit second, longd, kp;
  bit e_s, e_l, e_r, e_d, e_b;
  // observed DUT pulse bookkeeping
  int n_s, n_l, n_r, n_d, n_any, t_s, t_l, t_r, t_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    p1_t = -1; rel_t = -1; second = 0; longd = 0; kp = 1'b1;
  endtask

  task automatic model(input bit k);
    {e_s, e_l, e_r, e_d} = '0;
    if (p1_t < 0) begin
      if (k && !kp) begin p1_t = t; rel_t = -1; second = 0; longd = 0; end
    end else if (second) begin
      if (!k) begin e_d = 1; p1_t = -1; end
    end else if (rel_t >= 0) begin
      if (k) second = 1;
      else if (t - rel_t == D) begin e_s = 1; p1_t = -1; end
    end else if (!longd) begin
      if (!k) rel_t = t;
      else if (t - p1_t == L) begin e_l = 1; longd = 1; end
    end else begin
      if (!k) p1_t = -1;
      else if (R > 0 && (t - p1_t - L) % R == 0) e_r = 1;
    end
    e_b = (p1_t >= 0);
    kp  = k;
  endtask

  task automatic step(input bit k);
    @(negedge clk);
    key_state = k;
    @(posedge clk);
    t++;
    model(k);
    #1;
    chk("cycle", {short_press, long_press, repeat_press, double_click, busy},
        {e_s, e_l, e_r, e_d, e_b});
    if (short_press)  begin n_s++; t_s = t; end
    if (long_press)   begin n_l++; t_l = t; end
    if (repeat_press) begin n_r++; t_r = t; end
    if (double_click) begin n_d++; t_d = t; end
    n_any += short_press + long_press + repeat_press + double_click;
  endtask

  task automatic steps(input bit k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  initial begin
    int t0, a0, s0, r0, l0;
    // reset with key held
    rst = 1'b0; key_state = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset_out", {short_press, long_press, repeat_press, double_click, busy}, 5'b0);
    @(negedge clk) rst = 1'b1;
    model_reset();
    a0 = n_any;
    steps(1, 6);
    chk("held_thru_reset_pulses", n_any - a0, 0);
    chk("held_thru_reset_busy", busy, 1'b0);
    steps(0, 2);
    step(1);
    chk("repress_busy", busy, 1'b1);
    steps(0, 12);

    // short press
    t0 = t + 1; a0 = n_any; s0 = n_s;
    steps(1, 10); steps(0, 12);
    chk("short_count", n_s - s0, 1);
    chk("short_time", t_s, t0 + 10 + D);
    chk("short_only", n_any - a0, 1);

    // double click
    t0 = t + 1; a0 = n_any; s0 = n_s;
    steps(1, 5); steps(0, 3); steps(1, 4); steps(0, 12);
    chk("dbl_time", t_d, t0 + 12);
    chk("dbl_no_short", n_s - s0, 0);
    chk("dbl_only", n_any - a0, 1);

    // long hold with repeats
    t0 = t + 1; a0 = n_any; r0 = n_r; l0 = n_l;
    steps(1, 40);
    chk("long_time", t_l, t0 + L);
    chk("long_count", n_l - l0, 1);
    chk("repeat_count", n_r - r0, 3);
    chk("repeat_last", t_r, t0 + L + 3 * R);
    step(0);
    chk("hold_release_busy", busy, 1'b0);
    a0 = n_any;
    steps(0, 12);
    chk("hold_release_quiet", n_any - a0, 0);

    // release exactly at the long-press threshold
    t0 = t + 1; l0 = n_l; s0 = n_s;
    steps(1, L); steps(0, 12);
    chk("edge_no_long", n_l - l0, 0);
    chk("edge_short_time", t_s, t0 + L + D);
    chk("edge_short_count", n_s - s0, 1);

    // second press on the last gap cycle
    t0 = t + 1; s0 = n_s;
    steps(1, 3); steps(0, D); steps(1, 3); steps(0, 12);
    chk("gap_edge_dbl", t_d, t0 + 3 + D + 3);
    chk("gap_edge_no_short", n_s - s0, 0);

    // reset during hold
    steps(1, L + 3);
    chk("pre_reset_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1 chk("async_reset_out", {short_press, long_press, repeat_press, double_click, busy}, 5'b0);
    @(negedge clk) rst = 1'b1;
    model_reset();
    a0 = n_any;
    steps(1, 30);
    chk("post_reset_quiet", n_any - a0, 0);
    chk("post_reset_busy", busy, 1'b0);
    steps(0, 12);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      steps(1, $urandom_range(1, 45));
      steps(0, $urandom_range(1, 12));
    end
    steps(0, 12);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
